// File: rtl/dmem_arbiter.sv
// Core / DMA arbiter for the shared single-port data memory.
// Round-robin grants, bounded DMA burst lock, tagged one-cycle read return.
module dmem_arbiter #(
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CoreReq,
    input  logic              CoreWrite,
    input  logic [ADDR_W-1:0] CoreAddress,
    input  logic [DATA_W-1:0] CoreWriteData,
    output logic              CoreGnt,
    output logic              CoreRValid,
    output logic [DATA_W-1:0] CoreReadData,
    input  logic              DmaReq,
    input  logic              DmaWrite,
    input  logic              DmaLock,
    input  logic [ADDR_W-1:0] DmaAddress,
    input  logic [DATA_W-1:0] DmaWriteData,
    output logic              DmaGnt,
    output logic              DmaRValid,
    output logic [DATA_W-1:0] DmaReadData,
    output logic              WriteEnable,
    output logic              ReadEnable,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] WriteData,
    input  logic [DATA_W-1:0] ReadData
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {ROBIN, BURST} state_t;

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        tag_q, tag_d;
    logic              core_gnt, dma_gnt;
    logic              burst_hold;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ROBIN;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        core_gnt   = 1'b0;
        dma_gnt    = 1'b0;
        burst_hold = (state_q == BURST) && DmaReq && DmaLock;
        if (!rst) begin
            state_d = ROBIN;
            cnt_d   = '0;
        end else if (burst_hold && CoreReq && (cnt_q >= CNT_MAX)) begin
            core_gnt = 1'b1;
            state_d  = ROBIN;
            cnt_d    = '0;
        end else if (burst_hold) begin
            // only cycles where the core is kept waiting use up the burst
            dma_gnt = 1'b1;
            if (CoreReq && (cnt_q < CNT_MAX))
                cnt_d = cnt_q + CNT_ONE;
        end else begin
            state_d = ROBIN;
            cnt_d   = '0;
            if (CoreReq && (!DmaReq || last_q)) begin
                core_gnt = 1'b1;
            end else if (DmaReq) begin
                dma_gnt = 1'b1;
                if (DmaLock) begin
                    state_d = BURST;
                    cnt_d   = CNT_ONE;
                end
            end
        end
        if (core_gnt)
            last_d = 1'b0;
        else if (dma_gnt)
            last_d = 1'b1;
    end

    always_comb begin
        WriteEnable = 1'b0;
        ReadEnable  = 1'b0;
        Address     = '0;
        WriteData   = '0;
        if (core_gnt) begin
            WriteEnable = CoreWrite;
            ReadEnable  = ~CoreWrite;
            Address     = CoreAddress;
            WriteData   = CoreWriteData;
        end else if (dma_gnt) begin
            WriteEnable = DmaWrite;
            ReadEnable  = ~DmaWrite;
            Address     = DmaAddress;
            WriteData   = DmaWriteData;
        end
    end

    assign tag_d = {dma_gnt & ~DmaWrite, core_gnt & ~CoreWrite};

    assign CoreGnt      = core_gnt;
    assign DmaGnt       = dma_gnt;
    assign CoreRValid   = tag_q[0];
    assign DmaRValid    = tag_q[1];
    assign CoreReadData = tag_q[0] ? ReadData : '0;
    assign DmaReadData  = tag_q[1] ? ReadData : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios plus random traffic
// checked against a behavioural arbitration / memory model.
module tb_dmem_arbiter;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          CoreReq, CoreWrite;
    logic [AW-1:0] CoreAddress;
    logic [DW-1:0] CoreWriteData;
    logic          CoreGnt, CoreRValid;
    logic [DW-1:0] CoreReadData;
    logic          DmaReq, DmaWrite, DmaLock;
    logic [AW-1:0] DmaAddress;
    logic [DW-1:0] DmaWriteData;
    logic          DmaGnt, DmaRValid;
    logic [DW-1:0] DmaReadData;
    logic          WriteEnable, ReadEnable;
    logic [AW-1:0] Address;
    logic [DW-1:0] WriteData;
    logic [DW-1:0] ReadData;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .CoreReq(CoreReq), .CoreWrite(CoreWrite),
        .CoreAddress(CoreAddress), .CoreWriteData(CoreWriteData),
        .CoreGnt(CoreGnt), .CoreRValid(CoreRValid),
        .CoreReadData(CoreReadData),
        .DmaReq(DmaReq), .DmaWrite(DmaWrite), .DmaLock(DmaLock),
        .DmaAddress(DmaAddress), .DmaWriteData(DmaWriteData),
        .DmaGnt(DmaGnt), .DmaRValid(DmaRValid),
        .DmaReadData(DmaReadData),
        .WriteEnable(WriteEnable), .ReadEnable(ReadEnable),
        .Address(Address), .WriteData(WriteData),
        .ReadData(ReadData)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return 32'h11 * DW'(a);
    endfunction

    // memory: unwritten words hold 0x11*addr
    bit            mem_wr [512];
    logic [DW-1:0] mem_v  [512];
    always @(posedge clk) begin
        if (WriteEnable) begin
            mem_wr[Address] <= 1'b1;
            mem_v[Address]  <= WriteData;
        end
        if (ReadEnable)
            ReadData <= mem_wr[Address] ? mem_v[Address] : init_val(Address);
    end

    int total = 0;
    int bad   = 0;

    // reference model state
    int            m_last;
    int            m_streak;
    bit            m_locked;
    bit            sh_wr [512];
    logic [DW-1:0] sh_v  [512];
    bit            p_core, p_dma;
    logic [DW-1:0] p_cdata, p_ddata;

    int            e_win;
    logic          e_we, e_re, e_crv, e_drv;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_cdata, e_ddata;

    function automatic logic [DW-1:0] sh_read(input logic [AW-1:0] a);
        return sh_wr[a] ? sh_v[a] : init_val(a);
    endfunction

    task automatic model_reset();
        m_last   = 1;
        m_locked = 1'b0;
        m_streak = 0;
        p_core   = 1'b0;
        p_dma    = 1'b0;
    endtask

    task automatic predict();
        e_win = 0;
        if (rst === 1'b1) begin
            if (m_locked && DmaReq && DmaLock)
                e_win = (CoreReq && m_streak >= MB) ? 1 : 2;
            else if (CoreReq && DmaReq)
                e_win = (m_last == 1) ? 1 : 2;
            else if (CoreReq)
                e_win = 1;
            else if (DmaReq)
                e_win = 2;
        end
        e_we = 1'b0; e_re = 1'b0; e_addr = '0; e_wdata = '0;
        if (e_win == 1) begin
            e_we = CoreWrite; e_re = !CoreWrite;
            e_addr = CoreAddress; e_wdata = CoreWriteData;
        end else if (e_win == 2) begin
            e_we = DmaWrite; e_re = !DmaWrite;
            e_addr = DmaAddress; e_wdata = DmaWriteData;
        end
        e_crv   = p_core;
        e_cdata = p_core ? p_cdata : '0;
        e_drv   = p_dma;
        e_ddata = p_dma ? p_ddata : '0;
    endtask

    task automatic commit();
        bit kept;
        kept = m_locked && DmaLock && e_win == 2;
        if (e_win == 2) begin
            m_last = 1;
            if (kept) begin
                if (CoreReq && m_streak < MB) m_streak++;
            end else begin
                m_locked = DmaLock;
                m_streak = DmaLock ? 1 : 0;
            end
        end else begin
            m_locked = 1'b0;
            m_streak = 0;
            if (e_win == 1) m_last = 0;
        end
        p_core = (e_win == 1) && !CoreWrite;
        if (p_core) p_cdata = sh_read(CoreAddress);
        p_dma = (e_win == 2) && !DmaWrite;
        if (p_dma) p_ddata = sh_read(DmaAddress);
        if (e_we) begin
            sh_wr[e_addr] = 1'b1;
            sh_v[e_addr]  = e_wdata;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        commit();
        #1;
    endtask

    task automatic clear_inputs();
        CoreReq = 0; CoreWrite = 0; CoreAddress = '0; CoreWriteData = '0;
        DmaReq = 0; DmaWrite = 0; DmaLock = 0;
        DmaAddress = '0; DmaWriteData = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        CoreReq = 1; DmaReq = 1;
        @(negedge clk);
        total++;
        if ({CoreGnt, DmaGnt} !== 2'b00) begin
            bad++; $display("FAIL rst_gnt: got %b want 00", {CoreGnt, DmaGnt});
        end
        total++;
        if ({WriteEnable, ReadEnable, CoreRValid, DmaRValid} !== 4'b0) begin
            bad++;
            $display("FAIL rst_strobe: got %b want 0000",
                     {WriteEnable, ReadEnable, CoreRValid, DmaRValid});
        end
        total++;
        if (Address !== '0 || WriteData !== '0) begin
            bad++; $display("FAIL rst_bus: got %0h/%0h want 0/0", Address, WriteData);
        end
        @(posedge clk);
        #1;
        clear_inputs();
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_core_write_read();
        CoreReq = 1; CoreWrite = 1; CoreAddress = 9'd10;
        CoreWriteData = 32'hDEADBEEF;
        @(negedge clk); predict();
        total++;
        if (CoreGnt !== 1'b1 || WriteEnable !== 1'b1 || ReadEnable !== 1'b0) begin
            bad++;
            $display("FAIL cw_gnt: got gnt=%b we=%b re=%b want 1 1 0",
                     CoreGnt, WriteEnable, ReadEnable);
        end
        total++;
        if (Address !== 9'd10 || WriteData !== 32'hDEADBEEF) begin
            bad++; $display("FAIL cw_bus: got %0h/%0h want a/deadbeef", Address, WriteData);
        end
        advance();
        CoreWrite = 0;
        @(negedge clk); predict();
        total++;
        if (CoreGnt !== 1'b1 || ReadEnable !== 1'b1 || WriteEnable !== 1'b0) begin
            bad++;
            $display("FAIL cr_gnt: got gnt=%b re=%b we=%b want 1 1 0",
                     CoreGnt, ReadEnable, WriteEnable);
        end
        advance();
        CoreReq = 0;
        @(negedge clk); predict();
        total++;
        if (CoreRValid !== 1'b1 || CoreReadData !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL cr_ret: got v=%b d=%0h want 1 deadbeef", CoreRValid, CoreReadData);
        end
        total++;
        if (DmaRValid !== 1'b0 || DmaReadData !== '0) begin
            bad++; $display("FAIL cr_dma_quiet: got v=%b d=%0h want 0 0", DmaRValid, DmaReadData);
        end
        advance();
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            CoreReq = 1; CoreWrite = 0; CoreAddress = AW'(20 + i);
            DmaReq = 1; DmaWrite = 0; DmaLock = 0; DmaAddress = AW'(40 + i);
            @(negedge clk); predict();
            total++;
            if (CoreGnt !== (i % 2 == 0) || DmaGnt !== (i % 2 == 1)) begin
                bad++;
                $display("FAIL rr_%0d: got c=%b d=%b want c=%0d", i, CoreGnt, DmaGnt, (i % 2 == 0));
            end
            advance();
        end
        clear_inputs();
        @(negedge clk); predict(); advance();
    endtask

    task automatic test_burst();
        bit seq [7] = '{1, 1, 1, 1, 0, 1, 0};
        CoreReq = 1; CoreWrite = 0; CoreAddress = 9'd30;
        @(negedge clk); predict();
        total++;
        if (CoreGnt !== 1'b1) begin
            bad++; $display("FAIL bu_pre: got %b want 1", CoreGnt);
        end
        advance();
        DmaReq = 1; DmaWrite = 0; DmaLock = 1; DmaAddress = 9'd31;
        for (int i = 0; i < 7; i++) begin
            if (i == 5) DmaLock = 0;
            @(negedge clk); predict();
            total++;
            if (DmaGnt !== seq[i] || CoreGnt !== !seq[i]) begin
                bad++;
                $display("FAIL burst_%0d: got c=%b d=%b want d=%b", i, CoreGnt, DmaGnt, seq[i]);
            end
            advance();
        end
        clear_inputs();
        @(negedge clk); predict(); advance();
    endtask

    task automatic test_dma_reads();
        logic [DW-1:0] ex [3] = '{32'h11, 32'h22, 32'h33};
        for (int i = 0; i < 5; i++) begin
            clear_inputs();
            if (i < 3) begin
                DmaReq = 1; DmaAddress = AW'(i + 1);
            end
            @(negedge clk); predict();
            if (i >= 1 && i <= 3) begin
                total++;
                if (DmaRValid !== 1'b1 || DmaReadData !== ex[i-1]) begin
                    bad++;
                    $display("FAIL dr_%0d: got v=%b d=%0h want 1 %0h",
                             i, DmaRValid, DmaReadData, ex[i-1]);
                end
            end
            total++;
            if (CoreRValid !== 1'b0) begin
                bad++; $display("FAIL dr_core_%0d: got %b want 0", i, CoreRValid);
            end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        CoreReq = 1; CoreAddress = 9'd5;
        @(negedge clk); predict();
        total++;
        if (CoreGnt !== 1'b1 || ReadEnable !== 1'b1) begin
            bad++; $display("FAIL rm_gnt: got g=%b re=%b want 1 1", CoreGnt, ReadEnable);
        end
        @(posedge clk); commit(); #3;
        rst = 1'b0; model_reset(); #1;
        total++;
        if ({CoreGnt, DmaGnt, WriteEnable, ReadEnable, CoreRValid, DmaRValid} !== 6'b0) begin
            bad++;
            $display("FAIL rm_flags: got %b want 000000",
                     {CoreGnt, DmaGnt, WriteEnable, ReadEnable, CoreRValid, DmaRValid});
        end
        total++;
        if (Address !== '0 || CoreReadData !== '0) begin
            bad++; $display("FAIL rm_bus: got %0h/%0h want 0/0", Address, CoreReadData);
        end
        CoreReq = 0;
        @(posedge clk); #2; rst = 1'b1;
        @(negedge clk); predict();
        total++;
        if (CoreRValid !== 1'b0) begin
            bad++; $display("FAIL rm_noret: got %b want 0", CoreRValid);
        end
        advance();
        DmaReq = 1; DmaLock = 1; DmaAddress = 9'd6;
        @(negedge clk); predict();
        total++;
        if (DmaGnt !== 1'b1) begin
            bad++; $display("FAIL rm_lock: got %b want 1", DmaGnt);
        end
        @(posedge clk); commit(); #3;
        rst = 1'b0; model_reset();
        @(posedge clk); #2; rst = 1'b1;
        CoreReq = 1; CoreAddress = 9'd7;
        @(negedge clk); predict();
        total++;
        if (CoreGnt !== 1'b1 || DmaGnt !== 1'b0) begin
            bad++; $display("FAIL rm_tie: got c=%b d=%b want 1 0", CoreGnt, DmaGnt);
        end
        total++;
        if (DmaRValid !== 1'b0) begin
            bad++; $display("FAIL rm_dmaret: got %b want 0", DmaRValid);
        end
        advance();
        clear_inputs();
        @(negedge clk); predict(); advance();
    endtask

    task automatic test_interleave();
        for (int i = 0; i < 3; i++) begin
            clear_inputs();
            if (i == 0) begin CoreReq = 1; CoreAddress = 9'd5; end
            if (i == 1) begin DmaReq = 1; DmaAddress = 9'd6; end
            @(negedge clk); predict();
            if (i == 1) begin
                total++;
                if (CoreRValid !== 1'b1 || CoreReadData !== 32'h55 ||
                    DmaRValid !== 1'b0 || DmaReadData !== '0) begin
                    bad++;
                    $display("FAIL il_core: got cv=%b cd=%0h dv=%b dd=%0h want 1 55 0 0",
                             CoreRValid, CoreReadData, DmaRValid, DmaReadData);
                end
            end
            if (i == 2) begin
                total++;
                if (DmaRValid !== 1'b1 || DmaReadData !== 32'h66 ||
                    CoreRValid !== 1'b0 || CoreReadData !== '0) begin
                    bad++;
                    $display("FAIL il_dma: got dv=%b dd=%0h cv=%b cd=%0h want 1 66 0 0",
                             DmaRValid, DmaReadData, CoreRValid, CoreReadData);
                end
            end
            advance();
        end
    endtask

    task automatic test_random();
        bit c_wait = 0;
        bit d_wait = 0;
        for (int i = 0; i < 600; i++) begin
            if (!c_wait) begin
                CoreReq       = ($urandom_range(0, 9) < 6);
                CoreWrite     = 1'($urandom_range(0, 1));
                CoreAddress   = AW'($urandom_range(0, 7));
                CoreWriteData = $urandom;
            end
            if (!d_wait) begin
                DmaReq       = ($urandom_range(0, 9) < 6);
                DmaWrite     = 1'($urandom_range(0, 1));
                DmaLock      = ($urandom_range(0, 3) != 0);
                DmaAddress   = AW'($urandom_range(0, 7));
                DmaWriteData = $urandom;
            end
            @(negedge clk); predict();
            total++;
            if (CoreGnt !== (e_win == 1) || DmaGnt !== (e_win == 2)) begin
                bad++;
                $display("FAIL rnd_gnt %0d: got c=%b d=%b want win=%0d", i, CoreGnt, DmaGnt, e_win);
            end
            total++;
            if (WriteEnable !== e_we || ReadEnable !== e_re) begin
                bad++;
                $display("FAIL rnd_strobe %0d: got we=%b re=%b want %b %b",
                         i, WriteEnable, ReadEnable, e_we, e_re);
            end
            total++;
            if (Address !== e_addr || WriteData !== e_wdata) begin
                bad++;
                $display("FAIL rnd_bus %0d: got %0h/%0h want %0h/%0h",
                         i, Address, WriteData, e_addr, e_wdata);
            end
            total++;
            if (CoreRValid !== e_crv || CoreReadData !== e_cdata) begin
                bad++;
                $display("FAIL rnd_cret %0d: got %b/%0h want %b/%0h",
                         i, CoreRValid, CoreReadData, e_crv, e_cdata);
            end
            total++;
            if (DmaRValid !== e_drv || DmaReadData !== e_ddata) begin
                bad++;
                $display("FAIL rnd_dret %0d: got %b/%0h want %b/%0h",
                         i, DmaRValid, DmaReadData, e_drv, e_ddata);
            end
            c_wait = CoreReq && (e_win != 1);
            d_wait = DmaReq && (e_win != 2);
            advance();
        end
        clear_inputs();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_core_write_read();
        test_round_robin();
        test_burst();
        test_dma_reads();
        test_reset_mid();
        test_interleave();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter sharing the single-port 512-word data memory between the RISCV core load/store path (port C) and a DMA/debug loader (port D).
- Drives the memory strobes (WriteEnable, ReadEnable, Address, WriteData) that the bench monitors.
- Routes the one-cycle-latency ReadData back to the requester that issued the read.
- Round-robin fairness, plus a bounded DMA burst lock so the core cannot starve.

Parameters:
- ADDR_W, 9, memory word-address width
- DATA_W, 32, data width
- MAX_BURST, 4, maximum consecutive locked DMA grants while core is requesting (>=1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- CoreReq  in  1  core access request, held until CoreGnt
- CoreWrite  in  1  1 = store, 0 = load
- CoreAddress  in  ADDR_W  core word address
- CoreWriteData  in  DATA_W  core store data
- CoreGnt  out  1  core access issued this cycle
- CoreRValid  out  1  core load data valid
- CoreReadData  out  DATA_W  core load data
- DmaReq  in  1  DMA request
- DmaWrite  in  1  DMA store/load select
- DmaLock  in  1  DMA requests burst priority
- DmaAddress  in  ADDR_W  DMA word address
- DmaWriteData  in  DATA_W  DMA store data
- DmaGnt  out  1  DMA access issued this cycle
- DmaRValid  out  1  DMA load data valid
- DmaReadData  out  DATA_W  DMA load data
- WriteEnable  out  1  memory write strobe
- ReadEnable  out  1  memory read strobe
- Address  out  ADDR_W  memory address
- WriteData  out  DATA_W  memory write data
- ReadData  in  DATA_W  memory read data, valid the cycle after ReadEnable

Behaviour:
- State: FSM {ROBIN, BURST}; LastGnt (0 = core, 1 = DMA); BurstCnt (0..MAX_BURST); RetTag (2 bits: core-read-pending, DMA-read-pending).
- Reset (rst = 0, asynchronous):
  - FSM = ROBIN, LastGnt = 1 (core wins the first tie), BurstCnt = 0, RetTag = 0.
  - All outputs 0, including CoreRValid, DmaRValid, strobes and grants.
- Grant is combinational in the request cycle; at most one Gnt per cycle.
- Grant requires Req high and rst high.
- ROBIN:
  - Only one Req high: that port is granted.
  - Both high: grant the port opposite LastGnt.
  - A DMA grant with DmaLock = 1 moves FSM to BURST with BurstCnt = 1.
- BURST:
  - DmaReq and DmaLock high, and (CoreReq low or BurstCnt < MAX_BURST): grant DMA.
  - BurstCnt increments, saturating; it counts only cycles in which CoreReq is high.
  - BurstCnt = MAX_BURST with CoreReq high: grant core, return to ROBIN, BurstCnt = 0.
  - DmaReq or DmaLock low: return to ROBIN and arbitrate this same cycle as ROBIN.
- LastGnt updates on every granted cycle to the granted port.
- Memory strobes:
  - Winner's Address/WriteData are muxed out.
  - WriteEnable = Gnt & Write; ReadEnable = Gnt & ~Write.
  - Never both high.
  - No grant: strobes 0, Address/WriteData 0.
- Read return:
  - RetTag registers which port issued a read.
  - Next cycle: that port's RValid = 1, its ReadData = memory ReadData; the other port's ReadData = 0.
  - Back-to-back reads are fully pipelined (one per cycle).
  - Writes produce no RValid.
- Write-then-read to the same address in consecutive cycles returns the new data (memory write-first is guaranteed by the memory).
- Reset mid-operation: the pending read return is discarded (RValid stays 0) and BURST is aborted.
- Ungranted requester keeps its Req/address/data stable. The arbiter does not latch request fields.

Test Plan:
- Reset, then CoreReq = 1, CoreWrite = 1, CoreAddress = 9'd10, CoreWriteData = 32'hDEADBEEF alone.
  - Required: CoreGnt = 1 and WriteEnable = 1, Address = 10, same cycle.
  - Next cycle CoreWrite = 0: CoreRValid = 1 the following cycle with CoreReadData = 32'hDEADBEEF; DmaRValid = 0.
- Both request, no lock, for 4 cycles after reset.
  - Required grants: C, D, C, D; LastGnt alternates.
- DmaLock = 1, DmaReq and CoreReq held high, MAX_BURST = 4.
  - Required: 4 consecutive DmaGnt (the first from ROBIN, since LastGnt = 0 after a prior core grant), then CoreGnt on cycle 5, then ROBIN alternation.
- DMA reads at addresses 1, 2, 3 back-to-back, memory preloaded 32'h11/32'h22/32'h33.
  - Required: DmaRValid high 3 consecutive cycles with 32'h11, 32'h22, 32'h33; CoreRValid = 0 throughout.
- Core read granted, then rst driven low mid-cycle before the return.
  - Required: all outputs 0 immediately; no CoreRValid after reset release.
  - First tie after release goes to core.
- Interleaved core read (addr 5) and DMA read (addr 6) granted in consecutive cycles.
  - Required: CoreRValid then DmaRValid on consecutive cycles, each carrying its own address's data.
